// File: rtl/output_clock_forward.sv
// Forwards clk_i (or a /2(N+1) copy) off-chip via a DDR output stage; glitch-free start/stop, optional edge counter (OUTPUT_CLOCK_EDGE_COUNT_EN).
// Pin lags the state/phase registers by one clk_i cycle; start_i is accepted only while ready_o=1, never queued.
module output_clock_forward #(
    parameter int    DIV_WIDTH       = 4,
    parameter int    PREAMBLE_CYCLES = 16,
    parameter string DIFF_OUT        = "TRUE"
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 ready_o,
    output logic                 running_o,
    output logic                 sync_o,
    output logic [15:0]          edge_count_o,
    output logic                 O,
    output logic                 OB
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam logic [7:0] L_PRE_LAST = 8'(PREAMBLE_CYCLES - 1);
    localparam bit         L_DIFF     = (DIFF_OUT == "TRUE");

    logic [1:0]           r_state;
    logic [DIV_WIDTH-1:0] r_div_q;
    logic [DIV_WIDTH-1:0] r_hcnt;
    logic [7:0]           r_pre;
    logic                 r_phase;
    logic                 r_oddr_rise;
    logic                 r_oddr_fall;

    logic w_half_end;
    logic w_div_zero;
    logic w_start_ok;
    logic w_d_r;
    logic w_d_f;
    logic w_sync;
    logic w_pad;

    assign w_half_end = (r_hcnt == r_div_q);
    assign w_div_zero = (r_div_q == '0);
    assign w_start_ok = (r_state == S_IDLE) && start_i && en_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_div_q <= '0;
            r_hcnt  <= '0;
            r_pre   <= '0;
            r_phase <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_div_q <= div_i;
                        r_pre   <= '0;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!en_i) begin
                        r_state <= S_IDLE;
                    end else if (r_pre == L_PRE_LAST) begin
                        r_state <= S_RUN;
                        r_phase <= 1'b1;
                        r_hcnt  <= '0;
                    end else begin
                        r_pre <= r_pre + 8'd1;
                    end
                end
                S_RUN: begin
                    if (!w_div_zero) begin
                        if (w_half_end) begin
                            r_hcnt  <= '0;
                            r_phase <= ~r_phase;
                        end else begin
                            r_hcnt <= r_hcnt + DIV_WIDTH'(1);
                        end
                    end
                    // A stop landing on a half-period boundary must not open a new high half.
                    if (!en_i) begin
                        if (!w_div_zero && w_half_end) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_div_zero || w_half_end) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + DIV_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_d_r  = 1'b0;
        w_d_f  = 1'b0;
        w_sync = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_div_zero) begin
                    w_d_r  = 1'b1;
                    w_sync = 1'b1;
                end else begin
                    w_d_r  = r_phase;
                    w_d_f  = r_phase;
                    w_sync = r_phase && (r_hcnt == '0);
                end
            end
            S_STOP: begin
                if (!w_div_zero) begin
                    w_d_r = r_phase;
                    w_d_f = r_phase;
                end
            end
            default: begin
                w_d_r  = 1'b0;
                w_d_f  = 1'b0;
                w_sync = 1'b0;
            end
        endcase
    end

    // Same-edge DDR output: both halves captured on the rising edge, muxed by clk_i level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oddr_rise <= 1'b0;
            r_oddr_fall <= 1'b0;
        end else begin
            r_oddr_rise <= w_d_r;
            r_oddr_fall <= w_d_f;
        end
    end

    assign w_pad = clk_i ? r_oddr_rise : r_oddr_fall;

    generate
        if (L_DIFF) begin : g_diff
            assign O  = w_pad;
            assign OB = ~w_pad;
        end else begin : g_single
            assign O  = w_pad;
            assign OB = 1'b0;
        end
    endgenerate

    assign ready_o   = (r_state == S_IDLE);
    assign running_o = (r_state == S_RUN);
    assign sync_o    = w_sync;

`ifdef OUTPUT_CLOCK_EDGE_COUNT_EN
    logic [15:0] r_edge_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_edge_cnt <= '0;
        end else if (w_start_ok) begin
            r_edge_cnt <= '0;
        end else if (w_sync && (r_edge_cnt != 16'hFFFF)) begin
            r_edge_cnt <= r_edge_cnt + 16'd1;
        end
    end

    assign edge_count_o = r_edge_cnt;
`else
    assign edge_count_o = '0;
`endif

endmodule

// File: tb/tb_output_clock_forward.sv
// Directed bench for output_clock_forward: preamble, /1 and /N forwarding, stop paths, ignored starts, async reset.
module tb_output_clock_forward;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [3:0]  div;
    logic        ready;
    logic        running;
    logic        sync;
    logic [15:0] ecnt;
    logic        o;
    logic        ob;

    int vectors     = 0;
    int miscompares = 0;

`ifdef OUTPUT_CLOCK_EDGE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    output_clock_forward dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .start_i      (start),
        .div_i        (div),
        .ready_o      (ready),
        .running_o    (running),
        .sync_o       (sync),
        .edge_count_o (ecnt),
        .O            (o),
        .OB           (ob)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        start = 1'b0;
        div   = 4'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready",   32'(ready),   32'd1);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_sync",    32'(sync),    32'd0);
        chk("rst_ecnt",    32'(ecnt),    32'd0);
        chk("rst_o_hi",    32'(o),       32'd0);
        chk("rst_ob_hi",   32'(ob),      32'd1);
        mid();
        chk("rst_o_lo",    32'(o),       32'd0);
        tick();
        rst = 1'b0;

        // start with en low is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_no_en_ready", 32'(ready), 32'd1);

        // Test 1: div 0, preamble then phase copy of clk
        en = 1'b1; div = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_ready_drop", 32'(ready), 32'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t1_pre_o",       32'(o),       32'd0);
            chk("t1_pre_running", 32'(running), 32'd0);
            chk("t1_pre_sync",    32'(sync),    32'd0);
        end
        tick();
        chk("t1_run_running", 32'(running), 32'd1);
        chk("t1_run_sync0",   32'(sync),    32'd1);
        chk("t1_run_o0",      32'(o),       32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_o_high", 32'(o),    32'd1);
            chk("t1_ob_low", 32'(ob),   32'd0);
            chk("t1_sync",   32'(sync), 32'd1);
            mid();
            chk("t1_o_low",  32'(o),    32'd0);
        end
        en = 1'b0;
        tick();
        chk("t1_stop_running", 32'(running), 32'd0);
        tick();
        chk("t1_idle_ready", 32'(ready), 32'd1);
        chk("t1_idle_o",     32'(o),     32'd0);

        // Test 2: div 3, period 8, 10 edges in 80 RUN cycles
        en = 1'b1; div = 4'd3; start = 1'b1;
        tick();
        start = 1'b0; div = 4'd0;
        repeat (16) tick();
        for (int k = 0; k < 80; k++) begin
            if (k > 0) tick();
            chk("t2_sync", 32'(sync), 32'((k % 8) == 0));
            chk("t2_o",    32'(o),    (k == 0) ? 32'd0 : 32'(((k - 1) % 8) < 4));
        end
        tick();
        chk("t2_ecnt", 32'(ecnt), CNT_EN ? 32'd10 : 32'd0);
        chk("t2_sync80", 32'(sync), 32'd1);

        // Test 3: en dropped on the 2nd high cycle
        tick();
        chk("t3_o_h1", 32'(o), 32'd1);
        tick();
        chk("t3_o_h2", 32'(o), 32'd1);
        en = 1'b0;
        tick();
        chk("t3_o_h3",       32'(o),       32'd1);
        chk("t3_running",    32'(running), 32'd0);
        chk("t3_ready_stop", 32'(ready),   32'd0);
        chk("t3_sync_stop",  32'(sync),    32'd0);
        tick();
        chk("t3_o_h4",       32'(o),     32'd1);
        chk("t3_ready_idle", 32'(ready), 32'd1);
        mid();
        chk("t3_o_h4_lo",    32'(o),     32'd1);
        tick();
        chk("t3_o_low",  32'(o),    32'd0);
        chk("t3_ecnt",   32'(ecnt), CNT_EN ? 32'd11 : 32'd0);

        // Test 4: en dropped in ARM
        en = 1'b1; div = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_ready_arm", 32'(ready), 32'd0);
        chk("t4_ecnt_clr",  32'(ecnt),  32'd0);
        repeat (4) begin
            tick();
            chk("t4_arm_o",    32'(o),    32'd0);
            chk("t4_arm_sync", 32'(sync), 32'd0);
        end
        en = 1'b0;
        tick();
        chk("t4_ready_back", 32'(ready),   32'd1);
        chk("t4_running",    32'(running), 32'd0);
        repeat (20) begin
            tick();
            chk("t4_idle_o",    32'(o),    32'd0);
            chk("t4_idle_sync", 32'(sync), 32'd0);
        end
        en = 1'b1;
        repeat (3) tick();
        chk("t4_no_restart", 32'(ready), 32'd1);

        // Test 6: start in RUN with new div is ignored
        div = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        chk("t6_running", 32'(running), 32'd1);
        chk("t6_sync0",   32'(sync),    32'd1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("t6_o",     32'(o),     32'(((k - 1) % 6) < 3));
            chk("t6_sync",  32'(sync),  32'((k % 6) == 0));
            chk("t6_ready", 32'(ready), 32'd0);
            if (k == 2) begin
                start = 1'b1;
                div   = 4'd7;
            end
            if (k == 3) start = 1'b0;
        end
        chk("t6_ecnt", 32'(ecnt), CNT_EN ? 32'd3 : 32'd0);

        // Test 5: asynchronous reset mid-RUN while the pin is high
        rst = 1'b1;
        #1;
        chk("t5_o",       32'(o),       32'd0);
        chk("t5_ob",      32'(ob),      32'd1);
        chk("t5_sync",    32'(sync),    32'd0);
        chk("t5_running", 32'(running), 32'd0);
        chk("t5_ready",   32'(ready),   32'd1);
        chk("t5_ecnt",    32'(ecnt),    32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_post_ready", 32'(ready), 32'd1);
        chk("t5_post_o",     32'(o),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_clock_forward.md
Name: output_clock_forward

Overview:
- Transmit-side companion to the board's input clock buffering.
- Forwards the system clock, or an integer-divided copy of it, off-chip on a differential pair through an output DDR register.
- Guarantees glitch-free start and stop, a quiet preamble before the first edge, and no runt pulses.
- Sits at the board edge and drives the downstream digitizer or trigger-board clock input.

Parameters:
- DIV_WIDTH, 4, width of the divide-select input.
- PREAMBLE_CYCLES, 16, clk_i cycles the output is held low in ARM before the first forwarded edge (range 1..255).
- DIFF_OUT, "TRUE", "TRUE" drives O/OB through OBUFDS; "FALSE" drives O through OBUF and ties OB low.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  level enable; deasserting it requests a stop.
- start_i  input  1  single-cycle start request, accepted only while ready_o=1.
- div_i  input  DIV_WIDTH  divide select; latched on start acceptance.
- ready_o  output  1  high in IDLE; a start can be accepted.
- running_o  output  1  high in RUN.
- sync_o  output  1  one-cycle pulse coincident with each forwarded rising edge.
- edge_count_o  output  16  forwarded rising-edge count (see Optional Feature).
- O  output  1  forwarded clock, positive leg.
- OB  output  1  forwarded clock, negative leg.

Behaviour:
- Reset (async, asserted): state=IDLE; ready_o=1; running_o=0; sync_o=0; edge_count_o=0; ODDR rise/fall data=0, so O is low.
- ODDR in SAME_EDGE mode, clocked by clk_i, with rise data d_r and fall data d_f.
- div_q=0: in RUN, d_r=1 and d_f=0, so the output is a phase copy of clk_i.
- div_q=N>0: a phase bit toggles every N+1 cycles and d_r=d_f=phase, giving output period 2(N+1) cycles at 50% duty.
- Half-period counter is DIV_WIDTH bits, counts up from 0, and wraps at div_q.
- State machine, IDLE:
  - Output low; ready_o=1.
  - start_i=1 and en_i=1: latch div_q<=div_i, clear the preamble counter, go to ARM.
  - start_i while en_i=0: ignored.
- State machine, ARM:
  - Output low; ready_o=0.
  - After PREAMBLE_CYCLES cycles, go to RUN with phase=1.
  - en_i=0: go directly to IDLE.
- State machine, RUN:
  - running_o=1.
  - sync_o=1 in each cycle whose ODDR data starts a high level: every cycle when div_q=0; the cycle phase goes 0->1 otherwise. This includes the first RUN cycle.
  - en_i=0: go to STOP.
- State machine, STOP:
  - div_q=0: drive output low and go to IDLE next cycle.
  - div_q>0: finish the current half-period. If phase=1, complete the high half, then go low. If phase=0, go to IDLE when the low half completes.
  - No high pulse shorter than N+1 cycles is emitted.
  - sync_o=0 throughout.
- Output register latency: one clk_i cycle from the state/phase register to the pin.
- div_i changes outside start acceptance are ignored.
- start_i while not ready_o is ignored; there is no queueing.
- en_i reasserted during STOP does not abort the stop. A new start_i is required after IDLE is reached.
- Simultaneous start_i=1 and en_i=0 in IDLE: no start.
- Reset mid-RUN: output goes low asynchronously. A runt pulse is permitted only in this case.

Optional Feature:
- Macro: OUTPUT_CLOCK_EDGE_COUNT_EN.
- Defined:
  - edge_count_o increments on each sync_o pulse and saturates at 16'hFFFF.
  - Clears on ARM entry.
  - Holds its value through STOP and IDLE.
- Undefined: edge_count_o is tied to 0 and no counter logic is synthesized. The port remains for interface stability.

Test Plan:
1. Reset released, en_i=1, start_i pulse, div_i=0 -> ready_o drops next cycle; output low for 16 cycles; then running_o=1, O follows clk_i, and sync_o is high every cycle.
2. div_i=3, start -> after preamble, O is high 4 cycles and low 4 cycles (period 8); sync_o pulses once per 8 cycles; with the macro defined, edge_count_o=10 after 80 RUN cycles.
3. div_i=3, en_i dropped on the 2nd high cycle -> O stays high 2 more cycles, then goes low; ready_o=1 within 1 cycle of low; no pulse shorter than 4 cycles.
4. en_i dropped during ARM (cycle 5 of 16) -> returns to IDLE; O never toggles; sync_o never pulses.
5. rst_i asserted mid-RUN with div_i=2 -> O, sync_o, running_o go 0 asynchronously; ready_o=1; edge_count_o=0.
6. start_i pulsed in RUN with div_i changed to 7 -> ignored; period stays at the latched value; ready_o remains 0.
